// File: rtl/fetch_return_queue.sv
// fetch_return_queue: pairs in-order memory returns with their fetch pc and
// buffers them in a DEPTH-entry in-order queue feeding decode.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   req_valid/req_pc   fetch issued by the PC side; req_ready = slot available
//   mem_rsp_valid/...  one returned instruction per cycle, in request order
//   flush              redirect: drop all buffered and in-flight fetches
//   out_valid/out_pc/  head entry presented to decode; out_ready accepts it
//   out_instr/out_ready
//   err                sticky: a response arrived with nothing outstanding
module fetch_return_queue #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [WIDTH-1:0]  req_pc,
  output logic              req_ready,
  input  logic              mem_rsp_valid,
  input  logic [IWIDTH-1:0] mem_rsp_instr,
  input  logic              flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_pc,
  output logic [IWIDTH-1:0] out_instr,
  input  logic              out_ready,
  output logic              err
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  // Responses still owed by memory for flushed fetches can span several
  // flush epochs, so this counter gets headroom beyond one queue's worth.
  localparam int unsigned DROP_W = CNT_W + 4;

  logic [WIDTH-1:0]  slot_pc     [DEPTH];
  logic [IWIDTH-1:0] slot_instr  [DEPTH];
  logic [DEPTH-1:0]  slot_filled;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  fill_ptr;
  logic [CNT_W-1:0]  alloc_cnt;
  logic [CNT_W-1:0]  unfilled_cnt;
  logic [DROP_W-1:0] drop_cnt;

  logic              empty;
  logic              accept;
  logic              deq;
  logic              rsp_drop;
  logic              rsp_fill;
  logic              rsp_spurious;
  logic [DROP_W-1:0] drop_sum;
  logic [DROP_W-1:0] drop_on_flush;

  // Handshake and response classification from registered state.
  assign empty        = (alloc_cnt == '0);
  assign req_ready    = rst & ~flush & (alloc_cnt < CNT_W'(DEPTH));
  assign accept       = req_valid & req_ready;
  assign out_valid    = slot_filled[head];
  assign out_pc       = empty ? '0 : slot_pc[head];
  assign out_instr    = empty ? '0 : slot_instr[head];
  assign deq          = out_valid & out_ready & ~flush;
  assign rsp_drop     = mem_rsp_valid & ~flush & (drop_cnt != '0);
  assign rsp_fill     = mem_rsp_valid & ~flush & (drop_cnt == '0) & (unfilled_cnt != '0);
  assign rsp_spurious = mem_rsp_valid & ~flush & (drop_cnt == '0) & (unfilled_cnt == '0);

  // On flush every unfilled slot becomes a response to discard; a response
  // arriving in the flush cycle itself pays one of those off immediately.
  assign drop_sum      = drop_cnt + DROP_W'(unfilled_cnt);
  assign drop_on_flush = (mem_rsp_valid && (drop_sum != '0)) ? drop_sum - DROP_W'(1) : drop_sum;

  // Queue state. Accept, fill and dequeue always touch distinct slots:
  // tail is unallocated, the fill slot is allocated but unfilled, and the
  // head is filled when it dequeues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
      end
      slot_filled  <= '0;
      head         <= '0;
      tail         <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= '0;
      err          <= 1'b0;
    end else if (flush) begin
      slot_filled  <= '0;
      head         <= '0;
      tail         <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= drop_on_flush;
    end else begin
      if (accept) begin
        slot_pc[tail]     <= req_pc;
        slot_instr[tail]  <= '0;
        slot_filled[tail] <= 1'b0;
        tail              <= tail + PTR_W'(1);
      end
      if (rsp_fill) begin
        slot_instr[fill_ptr]  <= mem_rsp_instr;
        slot_filled[fill_ptr] <= 1'b1;
        fill_ptr              <= fill_ptr + PTR_W'(1);
      end
      if (deq) begin
        slot_filled[head] <= 1'b0;
        head              <= head + PTR_W'(1);
      end
      alloc_cnt    <= alloc_cnt + CNT_W'(accept) - CNT_W'(deq);
      unfilled_cnt <= unfilled_cnt + CNT_W'(accept) - CNT_W'(rsp_fill);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - DROP_W'(1);
      end
      if (rsp_spurious) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_return_queue.sv
// Testbench for fetch_return_queue: directed scenarios plus a randomized run
// against a queue-based reference model with an in-order memory stand-in.
module tb_fetch_return_queue;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned IWIDTH = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic [WIDTH-1:0]  req_pc;
  logic              req_ready;
  logic              mem_rsp_valid;
  logic [IWIDTH-1:0] mem_rsp_instr;
  logic              flush;
  logic              out_valid;
  logic [WIDTH-1:0]  out_pc;
  logic [IWIDTH-1:0] out_instr;
  logic              out_ready;
  logic              err;

  fetch_return_queue #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_instr(mem_rsp_instr),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of entries, count of responses to discard, sticky err.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } entry_t;

  entry_t      mq[$];
  int          m_drop;
  bit          m_err;
  logic [31:0] mem_q[$];   // instructions memory still owes, in order

  int checks;
  int errors;

  function automatic bit exp_req_ready();
    return rst && !flush && (mq.size() < int'(DEPTH));
  endfunction

  function automatic bit exp_out_valid();
    return (mq.size() > 0) && mq[0].filled;
  endfunction

  function automatic logic [31:0] exp_out_pc();
    return (mq.size() > 0) ? mq[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] exp_out_instr();
    return (mq.size() > 0) ? mq[0].instr : 32'h0;
  endfunction

  task automatic model_clear();
    mq.delete();
    mem_q.delete();
    m_drop = 0;
    m_err  = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    bit dq;
    int idx;
    int unf;
    if (!rst) begin
      model_clear();
      return;
    end
    acc = req_valid && exp_req_ready();
    dq  = exp_out_valid() && out_ready && !flush;
    if (flush) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      m_drop = m_drop + unf - (mem_rsp_valid ? 1 : 0);
      if (m_drop < 0) m_drop = 0;
      mq.delete();
    end else begin
      if (mem_rsp_valid) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          idx = -1;
          foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
          if (idx >= 0) begin
            mq[idx].instr  = mem_rsp_instr;
            mq[idx].filled = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      if (dq) void'(mq.pop_front());
      if (acc) begin
        entry_t e;
        e.pc = req_pc;
        e.instr = 32'h0;
        e.filled = 1'b0;
        mq.push_back(e);
        mem_q.push_back($urandom());
      end
    end
  endtask

  // One clock: model follows the edge, then stimulus resumes at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid     = 1'b0;
    req_pc        = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_instr = '0;
    flush         = 1'b0;
    out_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_clear();
    cycle();
    cycle();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      req_valid     = 1'($urandom());
      req_pc        = $urandom();
      mem_rsp_valid = 1'($urandom());
      mem_rsp_instr = $urandom();
      flush         = 1'($urandom());
      out_ready     = 1'($urandom());
      #1;
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 1'b0 || err !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: out_valid=%b req_ready=%b err=%b out_pc=%h out_instr=%h, required 0 0 0 0 0",
                 c, out_valid, req_ready, err, out_pc, out_instr);
      end
      cycle();
    end
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release req_ready got %b required 1", req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 1'b1;
    req_pc    = 32'h100;
    cycle();
    idle();
    cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_instr = 32'h0050_0093;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_before_rsp out_valid got %b required 0", out_valid);
    end
    cycle();
    idle();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL single_out got valid=%b pc=%h instr=%h required 1 00000100 00500093",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_pc    = 32'(4 * i);
      cycle();
    end
    idle();
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_req_ready got %b required 0", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_instr = 32'h1000 + 32'(i);
      cycle();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h1000 + 32'(i)) begin
        errors++;
        $display("FAIL full_drain[%0d] got valid=%b pc=%h instr=%h required 1 %h %h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), 32'h1000 + 32'(i));
      end
      cycle();
      if (i == 0) begin
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_ready_after_deq got %b required 1", req_ready);
        end
      end
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty_after_drain out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'h20;
    cycle();
    req_pc    = 32'h24;
    cycle();
    req_valid = 1'b0;
    flush     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_ready got %b required 0", req_ready);
    end
    cycle();
    flush     = 1'b0;
    req_valid = 1'b1;
    req_pc    = 32'h80;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_ready got %b required 1", req_ready);
    end
    cycle();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_instr = 32'hA0 + 32'(k);
      cycle();
      mem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (k < 2) begin
        if (out_valid !== 1'b0 || err !== 1'b0) begin
          errors++;
          $display("FAIL flush_drop[%0d] got valid=%b err=%b required 0 0", k, out_valid, err);
        end
      end else if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_instr !== 32'hA2 || err !== 1'b0) begin
        errors++;
        $display("FAIL flush_pair got valid=%b pc=%h instr=%h err=%b required 1 00000080 000000a2 0",
                 out_valid, out_pc, out_instr, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_pc    = 32'h300 + 32'(4 * i);
      cycle();
    end
    req_valid     = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_instr = 32'h11;
    cycle();
    mem_rsp_valid = 1'b0;
    out_ready     = 1'b1;
    req_valid     = 1'b1;
    req_pc        = 32'h400;
    #1;
    checks++;
    if (req_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300) begin
      errors++;
      $display("FAIL b2b_same_cycle got ready=%b valid=%b pc=%h required 0 1 00000300",
               req_ready, out_valid, out_pc);
    end
    cycle();
    out_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || out_pc !== 32'h304 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after_deq got ready=%b pc=%h valid=%b required 1 00000304 0",
               req_ready, out_pc, out_valid);
    end
    cycle();
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accepted_full req_ready got %b required 0", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_instr = 32'h20 + 32'(i);
      cycle();
    end
    mem_rsp_valid = 1'b0;
    out_ready     = 1'b1;
    pcs[0] = 32'h304; pcs[1] = 32'h308; pcs[2] = 32'h30C; pcs[3] = 32'h400;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== 32'h20 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_drain[%0d] got valid=%b pc=%h instr=%h required 1 %h %h",
                 i, out_valid, out_pc, out_instr, pcs[i], 32'h20 + 32'(i));
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_spurious();
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_instr = 32'hDEAD;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL spurious_pre err got %b required 0", err);
    end
    cycle();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'h0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL spurious[%0d] got err=%b valid=%b pc=%h ready=%b required 1 0 00000000 1",
                 c, err, out_valid, out_pc, req_ready);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req_valid     = ($urandom_range(0, 9) < 6);
      req_pc        = {$urandom()} & 32'hFFFF_FFFC;
      out_ready     = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 19) == 0);
      mem_rsp_valid = 1'b0;
      mem_rsp_instr = $urandom();
      if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_instr = mem_q.pop_front();
      end
      #1;
      checks++;
      if (req_ready !== exp_req_ready()) begin
        errors++;
        $display("FAIL rand_req_ready cyc %0d got %b required %b", c, req_ready, exp_req_ready());
      end
      checks++;
      if (out_valid !== exp_out_valid()) begin
        errors++;
        $display("FAIL rand_out_valid cyc %0d got %b required %b", c, out_valid, exp_out_valid());
      end
      checks++;
      if (out_pc !== exp_out_pc() || out_instr !== exp_out_instr()) begin
        errors++;
        $display("FAIL rand_out_data cyc %0d got pc=%h instr=%h required %h %h",
                 c, out_pc, out_instr, exp_out_pc(), exp_out_instr());
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL rand_err cyc %0d got %b required %b", c, err, m_err);
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle();
    model_clear();
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_back_to_back();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
